magnitude_compare_seq: RTL and testbench

//  Sequential, parametrised successor of the 2-bit red/green/blue magnitude comparator.
//  - Compares two WIDTH-bit unsigned operands MSB-first, DIGIT bits per cycle.
//  - Exits early on the first differing slice.
//  - Reports a registered one-hot result with a start/busy/done handshake.
//  - Keeps saturating per-outcome statistics counters.
//  - Sits between operand-producing logic and the RGB status/LED driver.

---
 rtl/magnitude_compare_seq.sv | 95 +++++++++
 tb/tb_magnitude_compare_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/magnitude_compare_seq.sv
// magnitude_compare_seq: MSB-first sliced unsigned compare with early exit, one-hot result and saturating outcome counters
// Ports: start samples a/b; busy while slicing; done pulses as red(a>b)/green(a==b)/blue(a<b) update;
//        clr_cnt clears cnt_gt/cnt_eq/cnt_lt; rst_n is a synchronous active-low reset.
module magnitude_compare_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_cnt,
  output logic             busy,
  output logic             done,
  output logic             red,
  output logic             green,
  output logic             blue,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_lt
);
  localparam int N  = WIDTH / DIGIT;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [IW-1:0]    idx;
  logic [DIGIT-1:0] sa, sb;
  logic             gt, lt, last;
  // shadows shift left each RUN cycle so the slice under test is always the top DIGIT bits
  assign sa   = a_sh[WIDTH-1 -: DIGIT];
  assign sb   = b_sh[WIDTH-1 -: DIGIT];
  assign gt   = sa > sb;
  assign lt   = sa < sb;
  assign last = gt || lt || idx == '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      red    <= 1'b0;
      green  <= 1'b0;
      blue   <= 1'b0;
      cnt_gt <= '0;
      cnt_eq <= '0;
      cnt_lt <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      idx    <= '0;
    end else begin
      done <= 1'b0;
      // a clear on the DONE-entry edge suppresses counting that result
      if (clr_cnt) begin
        cnt_gt <= '0;
        cnt_eq <= '0;
        cnt_lt <= '0;
      end else if (state == RUN && last) begin
        cnt_gt <= cnt_gt + CNT_W'(gt && !(&cnt_gt));
        cnt_eq <= cnt_eq + CNT_W'(!gt && !lt && !(&cnt_eq));
        cnt_lt <= cnt_lt + CNT_W'(lt && !(&cnt_lt));
      end
      case (state)
        IDLE, DONE: begin
          state <= start ? RUN : IDLE;
          busy  <= start;
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            idx  <= IW'(N - 1);
          end
        end
        RUN: begin
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            red   <= gt;
            green <= !gt && !lt;
            blue  <= lt;
          end else begin
            idx  <= idx - IW'(1);
            a_sh <= a_sh << DIGIT;
            b_sh <= b_sh << DIGIT;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_magnitude_compare_seq.sv
// tb_magnitude_compare_seq: randomized scenario bench for magnitude_compare_seq against an arithmetic reference model
module tb_magnitude_compare_seq;
  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr_cnt = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, red, green, blue;
  logic [15:0] cnt_gt, cnt_eq, cnt_lt;
  logic busy2, done2, red2, green2, blue2;
  logic [1:0] cnt_gt2, cnt_eq2, cnt_lt2;
  int errors = 0, checks = 0;
  int m_gt = 0, m_eq = 0, m_lt = 0;
  logic [2:0] m_rgb = 3'b000;

  always #5 clk = ~clk;

  magnitude_compare_seq #(.WIDTH(W), .DIGIT(D), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .clr_cnt(clr_cnt),
    .busy(busy), .done(done), .red(red), .green(green), .blue(blue),
    .cnt_gt(cnt_gt), .cnt_eq(cnt_eq), .cnt_lt(cnt_lt));

  magnitude_compare_seq #(.WIDTH(W), .DIGIT(D), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .clr_cnt(clr_cnt),
    .busy(busy2), .done(done2), .red(red2), .green(green2), .blue(blue2),
    .cnt_gt(cnt_gt2), .cnt_eq(cnt_eq2), .cnt_lt(cnt_lt2));

  function automatic int sat(input int v, input int m);
    return v > m ? m : v;
  endfunction

  // position (1..N) of the first differing DIGIT-wide slice from the MSB, N when equal
  function automatic int first_diff(input int x, input int y);
    int mask = (1 << D) - 1;
    for (int k = 1; k <= N; k++)
      if (((x >> (W - k * D)) & mask) != ((y >> (W - k * D)) & mask)) return k;
    return N;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_gt = 0;
    m_eq = 0;
    m_lt = 0;
    m_rgb = 3'b000;
  endtask

  task automatic run_compare(input int av, input int bv, input bit pulse, input bit clr);
    int k = first_diff(av, bv);
    logic [2:0] exp_rgb = {av > bv, av == bv, av < bv};
    start = 1'b1;
    a = W'(av);
    b = W'(bv);
    step();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    for (int j = 1; j <= k; j++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || busy2 !== 1'b1) begin
        errors++;
        $display("FAIL run_busy a=%h b=%h cycle=%0d: busy=%b done=%b busy2=%b, expected busy=1 done=0", av[7:0], bv[7:0], j, busy, done, busy2);
      end
      checks++;
      if ({red, green, blue} !== m_rgb) begin
        errors++;
        $display("FAIL rgb_hold cycle=%0d: rgb=%b, expected %b", j, {red, green, blue}, m_rgb);
      end
      if (pulse && j == 1) start = 1'b1;
      if (j == k) clr_cnt = clr;
      step();
      start = 1'b0;
      clr_cnt = 1'b0;
    end
    m_rgb = exp_rgb;
    if (clr) model_reset();
    else begin
      m_gt += int'(av > bv);
      m_eq += int'(av == bv);
      m_lt += int'(av < bv);
    end
    if (clr) m_rgb = exp_rgb;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || done2 !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle a=%h b=%h k=%0d: busy=%b done=%b done2=%b, expected busy=0 done=1", av[7:0], bv[7:0], k, busy, done, done2);
    end
    checks++;
    if ({red, green, blue} !== exp_rgb || {red2, green2, blue2} !== exp_rgb) begin
      errors++;
      $display("FAIL result a=%h b=%h: rgb=%b rgb2=%b, expected %b", av[7:0], bv[7:0], {red, green, blue}, {red2, green2, blue2}, exp_rgb);
    end
    checks++;
    if (cnt_gt !== 16'(sat(m_gt, 65535)) || cnt_eq !== 16'(sat(m_eq, 65535)) || cnt_lt !== 16'(sat(m_lt, 65535))) begin
      errors++;
      $display("FAIL counters: gt=%0d eq=%0d lt=%0d, expected %0d %0d %0d", cnt_gt, cnt_eq, cnt_lt, m_gt, m_eq, m_lt);
    end
    checks++;
    if (cnt_gt2 !== 2'(sat(m_gt, 3)) || cnt_eq2 !== 2'(sat(m_eq, 3)) || cnt_lt2 !== 2'(sat(m_lt, 3))) begin
      errors++;
      $display("FAIL counters_sat: gt=%0d eq=%0d lt=%0d, expected %0d %0d %0d", cnt_gt2, cnt_eq2, cnt_lt2, sat(m_gt, 3), sat(m_eq, 3), sat(m_lt, 3));
    end
  endtask

  task automatic test_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {red, green, blue} !== m_rgb || cnt_gt !== 16'(sat(m_gt, 65535)) || cnt_eq !== 16'(sat(m_eq, 65535)) || cnt_lt !== 16'(sat(m_lt, 65535))) begin
        errors++;
        $display("FAIL idle_hold: busy=%b done=%b rgb=%b cnt=%0d/%0d/%0d, expected busy=0 done=0 rgb=%b cnt=%0d/%0d/%0d", busy, done, {red, green, blue}, cnt_gt, cnt_eq, cnt_lt, m_rgb, m_gt, m_eq, m_lt);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({busy, done, red, green, blue} !== 5'b0 || {cnt_gt, cnt_eq, cnt_lt} !== 48'b0 || {busy2, done2, red2, green2, blue2} !== 5'b0 || {cnt_gt2, cnt_eq2, cnt_lt2} !== 6'b0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b rgb=%b cnt=%0d/%0d/%0d cnt2=%0d/%0d/%0d, expected all 0", tag, busy, done, {red, green, blue}, cnt_gt, cnt_eq, cnt_lt, cnt_gt2, cnt_eq2, cnt_lt2);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    check_zero("reset_state");
    rst_n = 1'b1;
    model_reset();
    test_idle(2);
  endtask

  task automatic test_red();
    run_compare('hA5, 'h25, 1'b0, 1'b0);
    test_idle(2);
  endtask

  task automatic test_equal();
    run_compare('h3C, 'h3C, 1'b0, 1'b0);
    test_idle(1);
  endtask

  task automatic test_less_start_in_run();
    run_compare('h12, 'h13, 1'b1, 1'b0);
    test_idle(1);
  endtask

  task automatic test_back_to_back();
    run_compare('h40, 'h80, 1'b0, 1'b0);
    run_compare('hC7, 'hC6, 1'b0, 1'b0);
    start = 1'b1;
    a = 8'h55;
    b = 8'h55;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_busy: busy=%b, expected 1", busy);
    end
    step();
    rst_n = 1'b0;
    step();
    check_zero("reset_mid_compare");
    rst_n = 1'b1;
    model_reset();
    test_idle(6);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      int bv = $urandom_range(0, 254);
      run_compare($urandom_range(bv + 1, 255), bv, 1'b0, 1'b0);
    end
    checks++;
    if (cnt_gt2 !== 2'd3 || cnt_gt !== 16'd5) begin
      errors++;
      $display("FAIL saturate: cnt_gt2=%0d cnt_gt=%0d, expected 3 and 5", cnt_gt2, cnt_gt);
    end
    run_compare('h0F, 'h0E, 1'b0, 1'b1);
    checks++;
    if ({cnt_gt, cnt_eq, cnt_lt} !== 48'b0 || {cnt_gt2, cnt_eq2, cnt_lt2} !== 6'b0) begin
      errors++;
      $display("FAIL clr_on_done: cnt=%0d/%0d/%0d cnt2=%0d/%0d/%0d, expected all 0", cnt_gt, cnt_eq, cnt_lt, cnt_gt2, cnt_eq2, cnt_lt2);
    end
    test_idle(1);
    run_compare('h20, 'h20, 1'b0, 1'b0);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    m_eq = 0;
    test_idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int av = $urandom_range(0, 255);
      int bv = $urandom_range(0, 3) == 0 ? av : ($urandom_range(0, 1) == 0 ? (av ^ $urandom_range(0, 15)) : $urandom_range(0, 255));
      run_compare(av, bv, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 0) test_idle($urandom_range(1, 2));
    end
  endtask

  initial begin
    test_reset();
    test_red();
    test_equal();
    test_less_start_in_run();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
